mod12_count_tracker: RTL and testbench

Downstream companion to the mod-12 up/down counter. Samples the counter's 4-bit output every cycle together with the control inputs the counter was given, checks each transition against mod-12 rules, and keeps a wrap (epoch) count. Wraps, loads and illegal transitions go into a small show-ahead event FIFO, drained through a valid/ready port by the consumer (status logic or bench).

---
 rtl/mod12_count_tracker.sv | 144 ++++++++++++++
 tb/tb_mod12_count_tracker.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mod12_count_tracker.sv
// Tracker for a mod-12 up/down counter: checks every sampled transition against
// the controls registered one cycle earlier, counts wraps, and queues events.
module mod12_count_tracker #(
   parameter int EPOCH_W = 8,
   parameter int DEPTH   = 4
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [3:0]         count_in,
   input  logic [3:0]         datain_in,
   input  logic               load_in,
   input  logic               mode_in,
   output logic               ev_valid,
   input  logic               ev_ready,
   output logic [2:0]         ev_code,
   output logic [3:0]         ev_value,
   output logic [EPOCH_W-1:0] ev_epoch,
   output logic [EPOCH_W-1:0] epoch,
   output logic               err,
   output logic               ovf
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [PTR_W:0] DEPTH_U = (PTR_W + 1)'(DEPTH);

   localparam logic [2:0] EV_WRAP_UP   = 3'd3;
   localparam logic [2:0] EV_WRAP_DOWN = 3'd4;
   localparam logic [2:0] EV_LOAD      = 3'd5;
   localparam logic [2:0] EV_ILLEGAL   = 3'd7;

   typedef enum logic {S_INIT, S_TRACK} state_t;

   typedef struct packed {
      logic [2:0]         code;
      logic [3:0]         value;
      logic [EPOCH_W-1:0] epoch;
   } event_t;

   state_t             state_q, state_d;
   logic [3:0]         prev_count_q, prev_datain_q;
   logic               prev_load_q, prev_mode_q;
   logic [EPOCH_W-1:0] epoch_q, epoch_d;
   logic               err_q, err_d;
   logic               ovf_q, ovf_d;

   event_t             mem_q [DEPTH];
   logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
   logic [PTR_W:0]     used_q, used_d;

   logic               push, pop, full, empty, do_push;
   logic [2:0]         code;
   event_t             head;

   // Classification: an event is assumed ILLEGAL until one of the legal
   // patterns matches; plain steps clear push.
   always_comb begin
      // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
      state_d = state_q;
      push    = 1'b0;
      code    = EV_ILLEGAL;
      epoch_d = epoch_q;
      err_d   = err_q;

      if (state_q == S_INIT) begin
         state_d = S_TRACK;
      end else begin
         push = 1'b1;
         if (count_in <= 4'd11) begin
            if (prev_load_q) begin
               if (count_in == prev_datain_q) code = EV_LOAD;
            end else if (prev_count_q <= 4'd11) begin
               if (prev_mode_q) begin
                  if (prev_count_q == 4'd11 && count_in == 4'd0)
                     code = EV_WRAP_UP;
                  else if (count_in == prev_count_q + 4'd1)
                     push = 1'b0;
               end else begin
                  if (prev_count_q == 4'd0 && count_in == 4'd11)
                     code = EV_WRAP_DOWN;
                  else if (count_in == prev_count_q - 4'd1)
                     push = 1'b0;
               end
            end
         end

         if (push && code == EV_WRAP_UP)   epoch_d = epoch_q + EPOCH_W'(1);
         if (push && code == EV_WRAP_DOWN) epoch_d = epoch_q - EPOCH_W'(1);
         if (push && code == EV_ILLEGAL)   err_d   = 1'b1;
      end
   end

   // A pop on a full FIFO frees the slot the same-cycle push needs.
   always_comb begin
      empty   = (used_q == '0);
      full    = (used_q == DEPTH_U);
      pop     = ev_ready && !empty;
      do_push = push && (!full || pop);
      ovf_d   = ovf_q | (push && full && !pop);
      used_d  = used_q + (PTR_W + 1)'(do_push) - (PTR_W + 1)'(pop);
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q       <= S_INIT;
         prev_count_q  <= '0;
         prev_datain_q <= '0;
         prev_load_q   <= 1'b0;
         prev_mode_q   <= 1'b0;
         epoch_q       <= '0;
         err_q         <= 1'b0;
         ovf_q         <= 1'b0;
         wr_ptr_q      <= '0;
         rd_ptr_q      <= '0;
         used_q        <= '0;
         // NOTE: storage is cleared on reset because the head fields must read 0 after reset.
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      end else begin
         state_q       <= state_d;
         prev_count_q  <= count_in;
         prev_datain_q <= datain_in;
         prev_load_q   <= load_in;
         prev_mode_q   <= mode_in;
         epoch_q       <= epoch_d;
         err_q         <= err_d;
         ovf_q         <= ovf_d;
         used_q        <= used_d;
         if (do_push) begin
            mem_q[wr_ptr_q] <= event_t'{code: code, value: count_in, epoch: epoch_d};
            wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
         end
         if (pop) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
   end

   assign head     = mem_q[rd_ptr_q];
   assign ev_valid = !empty;
   assign ev_code  = head.code;
   assign ev_value = head.value;
   assign ev_epoch = head.epoch;
   assign epoch    = epoch_q;
   assign err      = err_q;
   assign ovf      = ovf_q;

endmodule

// File: tb/tb_mod12_count_tracker.sv
// Directed bench for mod12_count_tracker: wraps, loads, illegal transitions,
// FIFO full/overflow/simultaneous push-pop and mid-stream reset.
module tb_mod12_count_tracker;

   logic       clk = 1'b0;
   logic       rst;
   logic [3:0] count_in, datain_in;
   logic       load_in, mode_in, ev_ready;
   logic       ev_valid, err, ovf;
   logic [2:0] ev_code;
   logic [3:0] ev_value;
   logic [7:0] ev_epoch, epoch;

   int n_cmp = 0;
   int n_bad = 0;

   mod12_count_tracker #(.EPOCH_W(8), .DEPTH(4)) dut (
      .clk       (clk),
      .rst       (rst),
      .count_in  (count_in),
      .datain_in (datain_in),
      .load_in   (load_in),
      .mode_in   (mode_in),
      .ev_valid  (ev_valid),
      .ev_ready  (ev_ready),
      .ev_code   (ev_code),
      .ev_value  (ev_value),
      .ev_epoch  (ev_epoch),
      .epoch     (epoch),
      .err       (err),
      .ovf       (ovf)
   );

   always #5 clk = ~clk;

   // Head snapshot {valid, code, value, epoch}: first hex digit is 8+code when valid.
   function automatic logic [15:0] head();
      return {ev_valid, ev_code, ev_value, ev_epoch};
   endfunction

   function automatic logic [9:0] stat();
      return {epoch, err, ovf};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [3:0] c);
      count_in = c;
      tick();
   endtask

   task automatic do_reset();
      rst = 1'b0;
      load_in = 1'b0; datain_in = 4'd0; ev_ready = 1'b0;
      tick();
      rst = 1'b1;
   endtask

   task automatic test_reset();
      rst = 1'b0; count_in = 4'd0; datain_in = 4'd0;
      load_in = 1'b0; mode_in = 1'b0; ev_ready = 1'b0;
      tick(); tick();
      n_cmp++;
      if (head() !== 16'h0000) begin
         n_bad++; $display("FAIL reset_head: got %h exp %h", head(), 16'h0000);
      end
      n_cmp++;
      if (stat() !== {8'd0, 1'b0, 1'b0}) begin
         n_bad++; $display("FAIL reset_status: got %h exp %h", stat(), {8'd0, 1'b0, 1'b0});
      end
      rst = 1'b1;
   endtask

   task automatic test_wrap_up();
      do_reset();
      mode_in = 1'b1;
      drive(4'd9);
      n_cmp++;
      if (ev_valid !== 1'b0) begin
         n_bad++; $display("FAIL wu_baseline_valid: got %b exp 0", ev_valid);
      end
      drive(4'd10); drive(4'd11); drive(4'd0);
      n_cmp++;
      if (head() !== 16'hB001) begin
         n_bad++; $display("FAIL wu_head: got %h exp %h", head(), 16'hB001);
      end
      drive(4'd1);
      n_cmp++;
      if (head() !== 16'hB001) begin
         n_bad++; $display("FAIL wu_head_stable: got %h exp %h", head(), 16'hB001);
      end
      n_cmp++;
      if (stat() !== {8'd1, 1'b0, 1'b0}) begin
         n_bad++; $display("FAIL wu_status: got %h exp %h", stat(), {8'd1, 1'b0, 1'b0});
      end
   endtask

   task automatic test_wrap_down_load();
      do_reset();
      mode_in = 1'b0;
      drive(4'd1); drive(4'd0); drive(4'd11);
      n_cmp++;
      if (head() !== 16'hCBFF) begin
         n_bad++; $display("FAIL wd_head: got %h exp %h", head(), 16'hCBFF);
      end
      n_cmp++;
      if (stat() !== {8'd255, 1'b0, 1'b0}) begin
         n_bad++; $display("FAIL wd_status: got %h exp %h", stat(), {8'd255, 1'b0, 1'b0});
      end
      drive(4'd10);
      load_in = 1'b1; datain_in = 4'd5;
      drive(4'd9);
      load_in = 1'b0; ev_ready = 1'b1;
      drive(4'd5);
      n_cmp++;
      if (head() !== 16'hD5FF) begin
         n_bad++; $display("FAIL load_head: got %h exp %h", head(), 16'hD5FF);
      end
      n_cmp++;
      if (stat() !== {8'd255, 1'b0, 1'b0}) begin
         n_bad++; $display("FAIL load_status: got %h exp %h", stat(), {8'd255, 1'b0, 1'b0});
      end
      drive(4'd4);
      n_cmp++;
      if (ev_valid !== 1'b0) begin
         n_bad++; $display("FAIL load_drained: got %b exp 0", ev_valid);
      end
      ev_ready = 1'b0;
   endtask

   task automatic test_illegal();
      do_reset();
      mode_in = 1'b1;
      drive(4'd3); drive(4'd7);
      n_cmp++;
      if (head() !== 16'hF700) begin
         n_bad++; $display("FAIL ill_jump_head: got %h exp %h", head(), 16'hF700);
      end
      n_cmp++;
      if (stat() !== {8'd0, 1'b1, 1'b0}) begin
         n_bad++; $display("FAIL ill_err_set: got %h exp %h", stat(), {8'd0, 1'b1, 1'b0});
      end
      drive(4'd13); drive(4'd0); drive(4'd1);
      ev_ready = 1'b1;
      drive(4'd2);
      n_cmp++;
      if (head() !== 16'hFD00) begin
         n_bad++; $display("FAIL ill_13_head: got %h exp %h", head(), 16'hFD00);
      end
      drive(4'd3);
      n_cmp++;
      if (head() !== 16'hF000) begin
         n_bad++; $display("FAIL ill_resync_head: got %h exp %h", head(), 16'hF000);
      end
      drive(4'd4);
      n_cmp++;
      if (ev_valid !== 1'b0) begin
         n_bad++; $display("FAIL ill_drained: got %b exp 0", ev_valid);
      end
      drive(4'd5);
      n_cmp++;
      if ({ev_valid, stat()} !== {1'b0, 8'd0, 1'b1, 1'b0}) begin
         n_bad++; $display("FAIL ill_empty_pop_sticky: got %h exp %h", {ev_valid, stat()}, {1'b0, 8'd0, 1'b1, 1'b0});
      end
      ev_ready = 1'b0;
   endtask

   task automatic test_overflow();
      do_reset();
      mode_in = 1'b1;
      drive(4'd11);
      for (int w = 1; w <= 5; w++) begin
         drive(4'd0);
         if (w == 4) begin
            n_cmp++;
            if (stat() !== {8'd4, 1'b0, 1'b0}) begin
               n_bad++; $display("FAIL ovf_full_no_ovf: got %h exp %h", stat(), {8'd4, 1'b0, 1'b0});
            end
         end
         if (w < 5) for (int v = 1; v <= 11; v++) drive(4'(v));
      end
      n_cmp++;
      if (head() !== 16'hB001) begin
         n_bad++; $display("FAIL ovf_head: got %h exp %h", head(), 16'hB001);
      end
      n_cmp++;
      if (stat() !== {8'd5, 1'b0, 1'b1}) begin
         n_bad++; $display("FAIL ovf_status: got %h exp %h", stat(), {8'd5, 1'b0, 1'b1});
      end
      ev_ready = 1'b1;
      for (int i = 1; i <= 3; i++) begin
         drive(4'(i));
         n_cmp++;
         if (head() !== {1'b1, 3'd3, 4'd0, 8'(i + 1)}) begin
            n_bad++; $display("FAIL ovf_drain%0d: got %h exp %h", i, head(), {1'b1, 3'd3, 4'd0, 8'(i + 1)});
         end
      end
      drive(4'd4);
      n_cmp++;
      if ({ev_valid, ovf} !== 2'b01) begin
         n_bad++; $display("FAIL ovf_drained: got %b exp %b", {ev_valid, ovf}, 2'b01);
      end
      ev_ready = 1'b0;
   endtask

   task automatic test_back_to_back();
      do_reset();
      mode_in = 1'b1;
      drive(4'd11);
      for (int w = 1; w <= 4; w++) begin
         drive(4'd0);
         for (int v = 1; v <= 11; v++) drive(4'(v));
      end
      ev_ready = 1'b1;
      drive(4'd0);
      n_cmp++;
      if (head() !== 16'hB002) begin
         n_bad++; $display("FAIL b2b_head: got %h exp %h", head(), 16'hB002);
      end
      n_cmp++;
      if (stat() !== {8'd5, 1'b0, 1'b0}) begin
         n_bad++; $display("FAIL b2b_status: got %h exp %h", stat(), {8'd5, 1'b0, 1'b0});
      end
      for (int i = 1; i <= 3; i++) begin
         drive(4'(i));
         n_cmp++;
         if (head() !== {1'b1, 3'd3, 4'd0, 8'(i + 2)}) begin
            n_bad++; $display("FAIL b2b_drain%0d: got %h exp %h", i, head(), {1'b1, 3'd3, 4'd0, 8'(i + 2)});
         end
      end
      drive(4'd4);
      n_cmp++;
      if (ev_valid !== 1'b0) begin
         n_bad++; $display("FAIL b2b_drained: got %b exp 0", ev_valid);
      end
      ev_ready = 1'b0;
   endtask

   task automatic test_mid_reset();
      do_reset();
      mode_in = 1'b1;
      drive(4'd11); drive(4'd0); drive(4'd5); drive(4'd13);
      n_cmp++;
      if ({head(), stat()} !== {16'hB001, 8'd1, 1'b1, 1'b0}) begin
         n_bad++; $display("FAIL mr_before: got %h exp %h", {head(), stat()}, {16'hB001, 8'd1, 1'b1, 1'b0});
      end
      rst = 1'b0;
      tick();
      n_cmp++;
      if ({head(), stat()} !== {16'h0000, 8'd0, 1'b0, 1'b0}) begin
         n_bad++; $display("FAIL mr_after: got %h exp %h", {head(), stat()}, {16'h0000, 8'd0, 1'b0, 1'b0});
      end
      rst = 1'b1;
      drive(4'd7);
      n_cmp++;
      if (ev_valid !== 1'b0) begin
         n_bad++; $display("FAIL mr_first_sample: got %b exp 0", ev_valid);
      end
      drive(4'd8);
      n_cmp++;
      if ({ev_valid, stat()} !== {1'b0, 8'd0, 1'b0, 1'b0}) begin
         n_bad++; $display("FAIL mr_resumed: got %h exp %h", {ev_valid, stat()}, {1'b0, 8'd0, 1'b0, 1'b0});
      end
   endtask

   initial begin
      test_reset();
      test_wrap_up();
      test_wrap_down_load();
      test_illegal();
      test_overflow();
      test_back_to_back();
      test_mid_reset();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
